// File: rtl/mc_ctrl_unit.sv
// Multicycle CPU control FSM: sequences fetch/decode/execute/memory/write-back
// and drives ALU op plus all datapath strobes, with a memory-wait timeout trap.
module mc_ctrl_unit #(
   parameter int TIMEOUT = 16,
   parameter int OP_W    = 6
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [5:0]      opcode,
   input  logic [5:0]      funct,
   input  logic            alu_zero,
   input  logic            alu_sign,
   input  logic            rs_sign,
   input  logic            mem_ready,
   output logic            mem_rd,
   output logic            mem_wr,
   output logic            i_or_d,
   output logic            ir_we,
   output logic            pc_we,
   output logic [1:0]      pc_src,
   output logic            reg_we,
   output logic            reg_dst,
   output logic            mem_to_reg,
   output logic            alu_src_a,
   output logic [1:0]      alu_src_b,
   output logic [OP_W-1:0] alu_op,
   output logic            retire,
   output logic            trap
);

   localparam logic [OP_W-1:0] ALU_NOP = 6'h00;
   localparam logic [OP_W-1:0] ALU_ADD = 6'h20;
   localparam logic [OP_W-1:0] ALU_SUB = 6'h02;
   localparam logic [OP_W-1:0] ALU_AND = 6'h03;
   localparam logic [OP_W-1:0] ALU_OR  = 6'h04;
   localparam logic [OP_W-1:0] ALU_XOR = 6'h05;
   localparam logic [OP_W-1:0] ALU_NOR = 6'h06;
   localparam logic [OP_W-1:0] ALU_DEC = 6'h3F;

   localparam logic [5:0] OPC_R    = 6'h00;
   localparam logic [5:0] OPC_J    = 6'h02;
   localparam logic [5:0] OPC_BEQ  = 6'h04;
   localparam logic [5:0] OPC_BGTZ = 6'h07;
   localparam logic [5:0] OPC_ADDI = 6'h08;
   localparam logic [5:0] OPC_ANDI = 6'h0C;
   localparam logic [5:0] OPC_ORI  = 6'h0D;
   localparam logic [5:0] OPC_XORI = 6'h0E;
   localparam logic [5:0] OPC_LW   = 6'h23;
   localparam logic [5:0] OPC_SW   = 6'h2B;

   localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

   typedef enum logic [3:0] {
      S_IDLE,
      S_FETCH,
      S_DECODE,
      S_EXEC_R,
      S_R_WB,
      S_EXEC_I,
      S_I_WB,
      S_MEM_ADDR,
      S_MEM_READ,
      S_MEM_WB,
      S_MEM_WRITE,
      S_BRANCH,
      S_JUMP,
      S_TRAP
   } state_t;

   state_t          state_q;
   state_t          state_d;
   state_t          dec_next;
   logic [CW-1:0]   cnt_q;
   logic [OP_W-1:0] r_op;
   logic            r_ok;
   logic [OP_W-1:0] i_op;
   logic            waiting;
   logic            tmo_hit;

   always_comb begin
      r_ok = 1'b1;
      r_op = ALU_NOP;
      unique case (funct)
         6'h20:   r_op = ALU_ADD;
         6'h22:   r_op = ALU_SUB;
         6'h24:   r_op = ALU_AND;
         6'h25:   r_op = ALU_OR;
         6'h26:   r_op = ALU_XOR;
         6'h27:   r_op = ALU_NOR;
         default: r_ok = 1'b0;
      endcase
   end

   always_comb begin
      i_op = ALU_NOP;
      unique case (opcode)
         OPC_ADDI: i_op = ALU_ADD;
         OPC_ANDI: i_op = ALU_AND;
         OPC_ORI:  i_op = ALU_OR;
         OPC_XORI: i_op = ALU_XOR;
         default:  i_op = ALU_NOP;
      endcase
   end

   // Illegal R-type funct is caught here so EXEC_R never sees it.
   always_comb begin
      dec_next = S_TRAP;
      unique case (opcode)
         OPC_R:            dec_next = r_ok ? S_EXEC_R : S_TRAP;
         OPC_LW, OPC_SW:   dec_next = S_MEM_ADDR;
         OPC_BEQ,
         OPC_BGTZ:         dec_next = S_BRANCH;
         OPC_ADDI,
         OPC_ANDI,
         OPC_ORI,
         OPC_XORI:         dec_next = S_EXEC_I;
         OPC_J:            dec_next = S_JUMP;
         default:          dec_next = S_TRAP;
      endcase
   end

   assign waiting = !mem_ready &&
                    (state_q == S_FETCH || state_q == S_MEM_READ ||
                     state_q == S_MEM_WRITE);
   assign tmo_hit = (TIMEOUT > 0) && waiting && (cnt_q == CNT_LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else if (state_d != state_q) begin
         cnt_q <= '0;
      end else if (waiting) begin
         cnt_q <= cnt_q + 1'b1;
      end
   end

   always_comb begin
      state_d    = state_q;
      mem_rd     = 1'b0;
      mem_wr     = 1'b0;
      i_or_d     = 1'b0;
      ir_we      = 1'b0;
      pc_we      = 1'b0;
      pc_src     = 2'd0;
      reg_we     = 1'b0;
      reg_dst    = 1'b0;
      mem_to_reg = 1'b0;
      alu_src_a  = 1'b0;
      alu_src_b  = 2'd0;
      alu_op     = ALU_NOP;
      retire     = 1'b0;
      trap       = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            state_d = S_FETCH;
         end
         S_FETCH: begin
            mem_rd    = 1'b1;
            alu_src_b = 2'd1;
            alu_op    = ALU_ADD;
            ir_we     = mem_ready;
            pc_we     = mem_ready;
            if (mem_ready) state_d = S_DECODE;
         end
         S_DECODE: begin
            alu_src_b = 2'd3;
            alu_op    = ALU_ADD;
            state_d   = dec_next;
         end
         S_EXEC_R: begin
            alu_src_a = 1'b1;
            alu_op    = r_op;
            state_d   = S_R_WB;
         end
         S_R_WB: begin
            reg_we  = 1'b1;
            reg_dst = 1'b1;
            retire  = 1'b1;
            state_d = S_FETCH;
         end
         S_EXEC_I: begin
            alu_src_a = 1'b1;
            alu_src_b = 2'd2;
            alu_op    = i_op;
            state_d   = S_I_WB;
         end
         S_I_WB: begin
            reg_we  = 1'b1;
            retire  = 1'b1;
            state_d = S_FETCH;
         end
         S_MEM_ADDR: begin
            alu_src_a = 1'b1;
            alu_src_b = 2'd2;
            alu_op    = ALU_ADD;
            state_d   = (opcode == OPC_SW) ? S_MEM_WRITE : S_MEM_READ;
         end
         S_MEM_READ: begin
            mem_rd = 1'b1;
            i_or_d = 1'b1;
            if (mem_ready) state_d = S_MEM_WB;
         end
         S_MEM_WB: begin
            reg_we     = 1'b1;
            mem_to_reg = 1'b1;
            retire     = 1'b1;
            state_d    = S_FETCH;
         end
         S_MEM_WRITE: begin
            mem_wr = 1'b1;
            i_or_d = 1'b1;
            retire = mem_ready;
            if (mem_ready) state_d = S_FETCH;
         end
         S_BRANCH: begin
            // rs_sign catches A = 0x80000000, where A-1 wraps positive.
            alu_src_a = 1'b1;
            pc_src    = 2'd1;
            retire    = 1'b1;
            state_d   = S_FETCH;
            if (opcode == OPC_BGTZ) begin
               alu_op = ALU_DEC;
               pc_we  = !alu_sign && !rs_sign;
            end else begin
               alu_op = ALU_SUB;
               pc_we  = alu_zero;
            end
         end
         S_JUMP: begin
            pc_we   = 1'b1;
            pc_src  = 2'd2;
            retire  = 1'b1;
            state_d = S_FETCH;
         end
         S_TRAP: begin
            trap = 1'b1;
         end
         default: begin
            state_d = S_TRAP;
         end
      endcase
      if (tmo_hit) state_d = S_TRAP;
   end

endmodule

// File: tb/tb_mc_ctrl_unit.sv
// Bench for mc_ctrl_unit: directed scenarios plus random instruction stream
// checked against per-instruction cycle/strobe counts derived from the ISA rules.
module tb_mc_ctrl_unit;

   localparam int TO = 16;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [5:0] opcode = '0;
   logic [5:0] funct = '0;
   logic       alu_zero = 1'b0;
   logic       alu_sign = 1'b0;
   logic       rs_sign = 1'b0;
   logic       mem_ready = 1'b0;
   logic       mem_rd, mem_wr, i_or_d, ir_we, pc_we;
   logic [1:0] pc_src, alu_src_b;
   logic       reg_we, reg_dst, mem_to_reg, alu_src_a;
   logic [5:0] alu_op;
   logic       retire, trap;

   int checks = 0;
   int fails  = 0;

   mc_ctrl_unit #(.TIMEOUT(TO), .OP_W(6)) dut (
      .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct),
      .alu_zero(alu_zero), .alu_sign(alu_sign), .rs_sign(rs_sign),
      .mem_ready(mem_ready), .mem_rd(mem_rd), .mem_wr(mem_wr),
      .i_or_d(i_or_d), .ir_we(ir_we), .pc_we(pc_we), .pc_src(pc_src),
      .reg_we(reg_we), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
      .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
      .retire(retire), .trap(trap)
   );

   always #5 clk = ~clk;

   wire [20:0] outs = {mem_rd, mem_wr, i_or_d, ir_we, pc_we, pc_src, reg_we,
                       reg_dst, mem_to_reg, alu_src_a, alu_src_b, alu_op,
                       retire, trap};

   // Reference tables: R-type funct -> op, I-type opcode -> op
   logic [5:0] rf_tab [6] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27};
   logic [5:0] ro_tab [6] = '{6'h20, 6'h02, 6'h03, 6'h04, 6'h05, 6'h06};
   logic [5:0] io_tab [4] = '{6'h08, 6'h0C, 6'h0D, 6'h0E};
   logic [5:0] iop_tab[4] = '{6'h20, 6'h03, 6'h04, 6'h05};
   logic [5:0] k_opc  [7] = '{6'h00, 6'h08, 6'h23, 6'h2B, 6'h04, 6'h07, 6'h02};

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      mem_ready = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      check("reset_outs", 32'(outs), 32'd0);
      rst_n = 1'b1;
   endtask

   // k: 0 R, 1 I-arith, 2 lw, 3 sw, 4 beq, 5 bgtz, 6 j
   task automatic run_instr(input int k, input int sel, input int wf,
                            input int wm, input logic z, input logic sg,
                            input logic rs);
      int cyc = 0, acc = 0, wc = 0;
      int nrd = 0, nwr = 0, nir = 0, npc = 0, nreg = 0, nret = 0;
      int we_at = -1;
      logic dst = 0, m2r = 0, done = 0;
      logic [1:0] psrc = 0, ex_b = 0;
      logic [5:0] dec_op = 0, ex_op = 0;
      int plan[2];
      int e_cyc, e_rd, e_wr, e_pc;
      logic taken, writes;
      logic [5:0] e_op;
      logic [1:0] e_b;
      plan[0] = wf;
      plan[1] = wm;
      opcode = (k == 1) ? io_tab[sel] : k_opc[k];
      funct = (k == 0) ? rf_tab[sel] : 6'($urandom_range(0, 63));
      alu_zero = z;
      alu_sign = sg;
      rs_sign = rs;
      while (!done && cyc < 40) begin
         @(negedge clk);
         if (mem_rd || mem_wr) mem_ready = (acc < 2) && (wc == plan[acc]);
         else mem_ready = 1'($urandom_range(0, 1));
         #1;
         if (cyc == 0)
            check("fetch_first", {mem_rd, i_or_d, alu_src_b, alu_op},
                  {1'b1, 1'b0, 2'd1, 6'h20});
         nrd += int'(mem_rd);
         nwr += int'(mem_wr);
         nir += int'(ir_we);
         npc += int'(pc_we);
         nret += int'(retire);
         if (reg_we) begin
            nreg++;
            we_at = cyc;
            dst = reg_dst;
            m2r = mem_to_reg;
         end
         if (pc_we && !ir_we) psrc = pc_src;
         if (cyc == wf + 1) dec_op = alu_op;
         if (cyc == wf + 2) begin
            ex_op = alu_op;
            ex_b = alu_src_b;
         end
         if (mem_rd || mem_wr) begin
            if (mem_ready) begin
               acc++;
               wc = 0;
            end else wc++;
         end
         if (retire) done = 1'b1;
         cyc++;
      end
      e_cyc = ((k <= 1 || k == 3) ? 4 : (k == 2) ? 5 : 3) + wf +
              ((k == 2 || k == 3) ? wm : 0);
      e_rd = 1 + wf + ((k == 2) ? 1 + wm : 0);
      e_wr = (k == 3) ? 1 + wm : 0;
      taken = (k == 6) || (k == 4 && z) || (k == 5 && !sg && !rs);
      e_pc = 1 + int'(taken);
      writes = (k <= 2);
      case (k)
         0: e_op = ro_tab[sel];
         1: e_op = iop_tab[sel];
         2, 3: e_op = 6'h20;
         4: e_op = 6'h02;
         5: e_op = 6'h3F;
         default: e_op = 6'h00;
      endcase
      e_b = (k == 1 || k == 2 || k == 3) ? 2'd2 : 2'd0;
      check($sformatf("k%0d_cycles", k), 32'(cyc), 32'(e_cyc));
      check($sformatf("k%0d_mem_rd", k), 32'(nrd), 32'(e_rd));
      check($sformatf("k%0d_mem_wr", k), 32'(nwr), 32'(e_wr));
      check($sformatf("k%0d_ir_we", k), 32'(nir), 32'd1);
      check($sformatf("k%0d_pc_we", k), 32'(npc), 32'(e_pc));
      check($sformatf("k%0d_reg_we", k), 32'(nreg), 32'(writes));
      check($sformatf("k%0d_retire", k), 32'(nret), 32'd1);
      check($sformatf("k%0d_dec_op", k), 32'(dec_op), 32'h20);
      check($sformatf("k%0d_ex_op", k), 32'(ex_op), 32'(e_op));
      if (k != 5) check($sformatf("k%0d_ex_srcb", k), 32'(ex_b), 32'(e_b));
      if (writes) begin
         check($sformatf("k%0d_we_at", k), 32'(we_at), 32'(e_cyc - 1));
         check($sformatf("k%0d_dst", k), {31'd0, dst}, 32'(k == 0));
         check($sformatf("k%0d_m2r", k), {31'd0, m2r}, 32'(k == 2));
      end
      if (taken) check($sformatf("k%0d_pc_src", k), 32'(psrc),
                       (k == 6) ? 32'd2 : 32'd1);
      check($sformatf("k%0d_trap", k), {31'd0, trap}, 32'd0);
   endtask

   task automatic illegal_run(input logic [5:0] op, input logic [5:0] fn,
                              input string tag);
      do_reset();
      opcode = op;
      funct = fn;
      mem_ready = 1'b1;
      repeat (3) @(negedge clk);
      #1;
      check({tag, "_trap"}, {31'd0, trap}, 32'd1);
      check({tag, "_quiet"}, 32'(outs[20:1]), 32'd0);
      repeat (4) @(negedge clk);
      #1;
      check({tag, "_held"}, 32'(outs), 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      check({tag, "_async_clr"}, 32'(outs), 32'd0);
   endtask

   initial begin
      int first;
      int nwr;
      do_reset();
      run_instr(0, 1, 0, 0, 1'b0, 1'b0, 1'b0);
      run_instr(2, 0, 0, 3, 1'b0, 1'b0, 1'b0);
      run_instr(5, 0, 0, 0, 1'b0, 1'b0, 1'b0);
      run_instr(5, 0, 0, 0, 1'b0, 1'b0, 1'b1);
      run_instr(4, 0, 0, 0, 1'b0, 1'b0, 1'b0);
      run_instr(4, 0, 1, 0, 1'b1, 1'b0, 1'b0);
      run_instr(6, 0, 2, 0, 1'b0, 1'b1, 1'b0);
      run_instr(3, 0, 1, 2, 1'b0, 1'b0, 1'b0);
      for (int n = 0; n < 40; n++) begin
         int k;
         k = $urandom_range(0, 6);
         run_instr(k, (k == 1) ? $urandom_range(0, 3) : $urandom_range(0, 5),
                   $urandom_range(0, 3), $urandom_range(0, 3),
                   1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 1)));
      end

      illegal_run(6'h3F, 6'h20, "bad_opc");
      illegal_run(6'h00, 6'h00, "bad_funct");

      do_reset();
      first = 0;
      for (int n = 1; n <= 40; n++) begin
         @(negedge clk);
         mem_ready = 1'b0;
         #1;
         if (trap && first == 0) first = n;
      end
      check("timeout_cycle", 32'(first), 32'(TO + 1));

      do_reset();
      opcode = 6'h2B;
      nwr = 0;
      for (int n = 0; n < 20 && nwr < 3; n++) begin
         @(negedge clk);
         mem_ready = mem_rd;
         #1;
         if (mem_wr) nwr++;
      end
      check("sw_wait_seen", 32'(nwr), 32'd3);
      #2;
      rst_n = 1'b0;
      #1;
      check("rst_mid_wr", {31'd0, mem_wr}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      mem_ready = 1'b0;
      #1;
      check("restart_fetch", {31'd0, mem_rd}, 32'd1);

      $display("End of test - %0d assertions evaluated, %0d failures",
               checks, fails);
      $finish;
   end

endmodule
